// File: rtl/prog_loader_pkg.sv
// Shared command codes, write-target selects and FSM state encoding for the
// byte-stream program loader.
package prog_loader_pkg;

   localparam logic [7:0] CMD_WR_IM = 8'hA1;
   localparam logic [7:0] CMD_WR_DM = 8'hA2;
   localparam logic [7:0] CMD_RUN   = 8'hA5;

   localparam logic SEL_IM = 1'b0;
   localparam logic SEL_DM = 1'b1;

   localparam int unsigned BYTES_PER_WORD = 4;

   typedef enum logic [2:0] {
      S_CMD,
      S_ADDR,
      S_LEN,
      S_DATA,
      S_WRITE,
      S_RUN
   } state_e;

   // A LEN byte of zero encodes a full 256-word frame.
   function automatic logic [8:0] len_to_count(input logic [7:0] len);
      return (len == 8'd0) ? 9'd256 : {1'b0, len};
   endfunction

endpackage

// File: rtl/word_assembler.sv
// Big-endian 4-byte word assembler; done_o flags the byte that completes a word
// and word_o presents that completed word in the same cycle.
module word_assembler
   import prog_loader_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        clr_i,
   input  logic        en_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        done_o
);

   logic [31:0] shift_q, shift_d;
   logic [1:0]  cnt_q, cnt_d;

   assign word_o = {shift_q[23:0], byte_i};
   assign done_o = en_i & ~clr_i & (cnt_q == 2'(BYTES_PER_WORD - 1));

   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      if (clr_i) begin
         shift_d = '0;
         cnt_d   = '0;
      end else if (en_i) begin
         shift_d = word_o;
         cnt_d   = cnt_q + 2'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/prog_loader.sv
// Loader FSM: parses CMD/ADDR/LEN frames from a byte stream, writes assembled
// words into instruction or data memory, then releases the CPU on RUN.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              byte_valid_i,
   input  logic [7:0]        byte_data_i,
   output logic              byte_ready_o,
   output logic              wr_en_o,
   output logic              wr_sel_o,
   output logic [ADDR_W-1:0] wr_addr_o,
   output logic [DATA_W-1:0] wr_data_o,
   output logic              cpu_start_o,
   output logic              err_o,
   output logic [15:0]       words_o
);

   state_e              state_q, state_d;
   logic                sel_q, sel_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [8:0]          cnt_q, cnt_d;
   logic [15:0]         words_q, words_d;
   logic                err_q, err_d;
   logic                start_q, start_d;
   logic                wr_en_q, wr_en_d;
   logic                byte_ready_q, byte_ready_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0]   wr_data_q, wr_data_d;

   logic                accept;
   logic                asm_en, asm_clr, asm_done;
   logic [31:0]         asm_word;

   assign accept  = byte_valid_i & byte_ready_q;
   assign asm_en  = accept & (state_q == S_DATA);
   assign asm_clr = accept & (state_q == S_LEN);

   word_assembler u_asm (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clr_i  (asm_clr),
      .en_i   (asm_en),
      .byte_i (byte_data_i),
      .word_o (asm_word),
      .done_o (asm_done)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q      <= S_CMD;
         sel_q        <= SEL_IM;
         addr_q       <= '0;
         cnt_q        <= '0;
         words_q      <= '0;
         err_q        <= 1'b0;
         start_q      <= 1'b0;
         wr_en_q      <= 1'b0;
         byte_ready_q <= 1'b1;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         addr_q       <= addr_d;
         cnt_q        <= cnt_d;
         words_q      <= words_d;
         err_q        <= err_d;
         start_q      <= start_d;
         wr_en_q      <= wr_en_d;
         byte_ready_q <= byte_ready_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      words_d = words_q;
      err_d   = err_q;
      case (state_q)
         S_CMD: if (accept) begin
            if (byte_data_i == CMD_WR_IM || byte_data_i == CMD_WR_DM) begin
               sel_d   = (byte_data_i == CMD_WR_DM) ? SEL_DM : SEL_IM;
               state_d = S_ADDR;
            end else if (byte_data_i == CMD_RUN) begin
               state_d = S_RUN;
            end else begin
               err_d = 1'b1;
            end
         end
         S_ADDR: if (accept) begin
            addr_d  = ADDR_W'(byte_data_i);
            state_d = S_LEN;
         end
         S_LEN: if (accept) begin
            cnt_d   = len_to_count(byte_data_i);
            state_d = S_DATA;
         end
         S_DATA: if (asm_done) state_d = S_WRITE;
         S_WRITE: begin
            addr_d  = addr_q + ADDR_W'(1);
            cnt_d   = cnt_q - 9'd1;
            words_d = words_q + 16'd1;
            state_d = (cnt_q == 9'd1) ? S_CMD : S_DATA;
         end
         S_RUN:   state_d = S_RUN;
         default: state_d = S_CMD;
      endcase
   end

   // Outputs are registered from the next state so they line up with state_q.
   always_comb begin
      wr_en_d      = (state_d == S_WRITE);
      byte_ready_d = (state_d == S_CMD) || (state_d == S_ADDR) ||
                     (state_d == S_LEN) || (state_d == S_DATA);
      start_d      = start_q | (state_d == S_RUN);
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      if (state_d == S_WRITE) begin
         wr_addr_d = addr_q;
         wr_data_d = asm_word;
      end
   end

   assign byte_ready_o = byte_ready_q;
   assign wr_en_o      = wr_en_q;
   assign wr_sel_o     = sel_q;
   assign wr_addr_o    = wr_addr_q;
   assign wr_data_o    = wr_data_q;
   assign cpu_start_o  = start_q;
   assign err_o        = err_q;
   assign words_o      = words_q;

endmodule
